// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (rclk domain): binary/Gray read
// pointer, empty / almost-empty flags, occupancy and sticky underflow detection.
module fifo_rd_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int AEMPTY_TH = 2
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              rinc,
   input  logic [ADDR_W:0]   rq2_wptr,
   input  logic              rerr_clr,
   output logic              rden,
   output logic [ADDR_W-1:0] raddr,
   output logic [ADDR_W:0]   rptr,
   output logic              rempty,
   output logic              raempty,
   output logic [ADDR_W:0]   rcount,
   output logic              runderflow
);

   localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];

   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] rbin_nxt;
   logic [ADDR_W:0] rgray_nxt;
   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] occ_nxt;
   logic            rd_ok;

   function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= ADDR_W; i++) begin : g_wbin
      assign wbin[i] = ^(rq2_wptr >> i);
   end

   // Reads are judged on the registered flag only, so rinc never reaches rempty
   // combinationally; a blocked read leaves the pointer untouched.
   assign rd_ok     = rinc & ~rempty;
   assign rden      = rd_ok;
   assign raddr     = rbin[ADDR_W-1:0];
   assign rbin_nxt  = rbin + {{ADDR_W{1'b0}}, rd_ok};
   assign rgray_nxt = bin2gray(rbin_nxt);
   assign occ_nxt   = wbin - rbin_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin       <= '0;
         rptr       <= '0;
         rempty     <= 1'b1;
         raempty    <= 1'b1;
         rcount     <= '0;
         runderflow <= 1'b0;
      end else begin
         rbin       <= rbin_nxt;
         rptr       <= rgray_nxt;
         rempty     <= (rgray_nxt == rq2_wptr);
         raempty    <= (occ_nxt <= AE_TH);
         rcount     <= occ_nxt;
         // A fresh underflow outranks a simultaneous clear.
         runderflow <= (rinc & rempty) | (runderflow & ~rerr_clr);
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised self-checking bench for fifo_rd_ctrl; the reference model tracks
// total reads/writes as plain integers and derives flags from their difference.
module tb_fifo_rd_ctrl;

   localparam int ADDR_W    = 4;
   localparam int AEMPTY_TH = 2;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int PMOD      = 2 * DEPTH;

   logic              rclk = 1'b0;
   logic              rrst_n;
   logic              rinc;
   logic [ADDR_W:0]   rq2_wptr;
   logic              rerr_clr;
   logic              rden;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W:0]   rptr;
   logic              rempty;
   logic              raempty;
   logic [ADDR_W:0]   rcount;
   logic              runderflow;

   int vectors = 0;
   int errors  = 0;

   // Reference model: unbounded read/write counts plus derived flags.
   int   m_rd;
   int   m_wr;
   int   m_count;
   logic m_empty;
   logic m_uf;

   fifo_rd_ctrl #(.ADDR_W(ADDR_W), .AEMPTY_TH(AEMPTY_TH)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
      .rerr_clr(rerr_clr), .rden(rden), .raddr(raddr), .rptr(rptr),
      .rempty(rempty), .raempty(raempty), .rcount(rcount),
      .runderflow(runderflow)
   );

   always #5 rclk = ~rclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [ADDR_W:0] g(input int x);
      logic [ADDR_W:0] b;
      b = x[ADDR_W:0];
      return b ^ (b >> 1);
   endfunction

   // {rptr, rempty, raempty, rcount, runderflow}
   function automatic logic [12:0] exp_post();
      logic [ADDR_W:0] c;
      c = m_count[ADDR_W:0];
      return {g(m_rd), m_empty, (m_count <= AEMPTY_TH), c, m_uf};
   endfunction

   function automatic logic [12:0] obs_post();
      return {rptr, rempty, raempty, rcount, runderflow};
   endfunction

   task automatic model_reset();
      m_rd = 0; m_wr = 0; m_count = 0; m_empty = 1'b1; m_uf = 1'b0;
   endtask

   // One rclk cycle: drive at the falling edge, capture {rden,raddr} before the
   // rising edge, advance the model on the edge, then settle.
   task automatic step(input logic inc, input int wr, input logic clr,
                       output logic [ADDR_W:0] pre_obs, output logic [ADDR_W:0] pre_exp);
      logic ok;
      int   rd4;
      @(negedge rclk);
      rinc = inc; rq2_wptr = g(wr); rerr_clr = clr;
      #1;
      ok      = inc & ~m_empty;
      rd4     = m_rd % DEPTH;
      pre_obs = {rden, raddr};
      pre_exp = {ok, rd4[ADDR_W-1:0]};
      @(posedge rclk);
      m_uf    = (inc & m_empty) | (m_uf & ~clr);
      m_rd    = m_rd + int'(ok);
      m_wr    = wr;
      m_count = (((m_wr - m_rd) % PMOD) + PMOD) % PMOD;
      m_empty = (m_count == 0);
      #1;
   endtask

   task automatic check_step(input string name, input logic inc, input int wr, input logic clr);
      logic [ADDR_W:0] po, pe;
      step(inc, wr, clr, po, pe);
      vectors++;
      if (po !== pe) begin
         errors++;
         $display("FAIL %s rden/raddr: got %b expected %b (rd=%0d)", name, po, pe, m_rd);
      end
      vectors++;
      if (obs_post() !== exp_post()) begin
         errors++;
         $display("FAIL %s state {rptr,rempty,raempty,rcount,runderflow}: got %b expected %b (rd=%0d wr=%0d)",
                  name, obs_post(), exp_post(), m_rd, m_wr);
      end
   endtask

   task automatic do_reset();
      rrst_n = 1'b0; rinc = 1'b0; rq2_wptr = '0; rerr_clr = 1'b0;
      repeat (2) @(posedge rclk);
      @(negedge rclk);
      rrst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if ({obs_post(), rden, raddr} !== {exp_post(), 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset values: got %b expected %b", {obs_post(), rden, raddr},
                  {exp_post(), 1'b0, 4'd0});
      end
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 3; i++) check_step("underflow", 1'b1, 0, 1'b0);
      check_step("underflow_clr", 1'b0, 0, 1'b1);
      // New underflow wins over a simultaneous clear.
      check_step("underflow_clr_race", 1'b1, 0, 1'b1);
      check_step("underflow_clr2", 1'b0, 0, 1'b1);
   endtask

   task automatic test_drain();
      check_step("drain_load", 1'b0, 5, 1'b0);
      for (int i = 0; i < 6; i++) check_step("drain", 1'b1, 5, 1'b0);
      check_step("drain_clr", 1'b0, 5, 1'b1);
   endtask

   task automatic test_wrap();
      int wr;
      int limit;
      logic [ADDR_W:0] prev;
      wr    = m_wr;
      limit = m_wr + 40;
      prev  = rptr;
      for (int i = 0; i < 150; i++) begin
         if (wr < limit && (wr - m_rd) < DEPTH && $urandom_range(0, 3) != 0) wr++;
         check_step("wrap", 1'($urandom_range(0, 4) != 0), wr, 1'($urandom_range(0, 7) == 0));
         vectors++;
         if ($countones(rptr ^ prev) > 1) begin
            errors++;
            $display("FAIL wrap gray_step: rptr %b -> %b", prev, rptr);
         end
         prev = rptr;
      end
      for (int i = 0; i < 20; i++) check_step("wrap_drain", 1'b1, wr, 1'b0);
      check_step("wrap_clr", 1'b0, wr, 1'b1);
   endtask

   task automatic test_full();
      do_reset();
      check_step("full_prep", 1'b0, 3, 1'b0);
      for (int i = 0; i < 3; i++) check_step("full_prep", 1'b1, 3, 1'b0);
      check_step("full", 1'b0, 19, 1'b0);
      check_step("full_hold", 1'b0, 19, 1'b0);
      check_step("full_read", 1'b1, 19, 1'b0);
   endtask

   task automatic test_same_cycle();
      check_step("same_prep", 1'b0, m_rd + 1, 1'b0);
      for (int i = 0; i < 4; i++) check_step("same_cycle", 1'b1, m_rd + 2, 1'b0);
   endtask

   task automatic test_mid_reset();
      do_reset();
      check_step("mid_prep", 1'b0, 12, 1'b0);
      for (int i = 0; i < 9; i++) check_step("mid_prep", 1'b1, 12, 1'b0);
      @(negedge rclk);
      rinc = 1'b1;
      #2 rrst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({obs_post(), rden, raddr} !== {exp_post(), 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL mid_reset async: got %b expected %b", {obs_post(), rden, raddr},
                  {exp_post(), 1'b0, 4'd0});
      end
      @(posedge rclk);
      @(negedge rclk);
      rq2_wptr = '0;
      rinc = 1'b0;
      rrst_n = 1'b1;
      check_step("mid_resume", 1'b0, 3, 1'b0);
      for (int i = 0; i < 4; i++) check_step("mid_resume", 1'b1, 3, 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_underflow();
      test_drain();
      test_wrap();
      test_full();
      test_same_cycle();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
